// File: rtl/pc_sequencer.sv
// pc_sequencer: control-flow sequencer driving the PC block's branch/stop inputs.
// Decodes the byte fetched at pc each cycle. It handles JMP, JZ, LOOP, DJNZ,
// single-level CALL/RET and HALT. Branch outputs are combinational so a branch
// lands on the same edge the PC would otherwise increment.
module pc_sequencer #(
   parameter logic [7:0] HALT_OP = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] pc,
   input  logic [7:0] instr,
   input  logic       zero_flag,
   output logic       branch_en,
   output logic [7:0] branch_pc,
   output logic       stop_en,
   output logic       halted,
   output logic [7:0] loop_cnt
);

   localparam int unsigned W = 8;

   localparam logic [W-1:0] OP_JMP  = 8'hF0;
   localparam logic [W-1:0] OP_JZ   = 8'hF1;
   localparam logic [W-1:0] OP_LOOP = 8'hF2;
   localparam logic [W-1:0] OP_DJNZ = 8'hF3;
   localparam logic [W-1:0] OP_CALL = 8'hF4;
   localparam logic [W-1:0] OP_RET  = 8'hF5;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_OPND  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [W-1:0] op_q, op_d;
   logic         take_q, take_d;
   logic [W-1:0] loop_cnt_q, loop_cnt_d;
   logic [W-1:0] link_q, link_d;

   logic         branch_en_c;
   logic [W-1:0] branch_pc_c;
   logic         stop_en_c;
   logic         halted_c;

   // Decode: next-state, register updates and same-cycle branch/stop outputs.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      take_d      = take_q;
      loop_cnt_d  = loop_cnt_q;
      link_d      = link_q;
      branch_en_c = 1'b0;
      branch_pc_c = '0;
      stop_en_c   = 1'b0;
      halted_c    = 1'b0;

      case (state_q)
         ST_FETCH: begin
            op_d = instr;
            if (instr == HALT_OP) begin
               take_d  = 1'b0;
               state_d = ST_HALT;
            end else begin
               case (instr)
                  OP_JMP: begin
                     take_d  = 1'b1;
                     state_d = ST_OPND;
                  end
                  OP_JZ: begin
                     take_d  = zero_flag;
                     state_d = ST_OPND;
                  end
                  OP_LOOP: begin
                     take_d  = 1'b0;
                     state_d = ST_OPND;
                  end
                  OP_DJNZ: begin
                     // Taken unless the counter is about to hit zero; 0 wraps to 255.
                     loop_cnt_d = loop_cnt_q - W'(1);
                     take_d     = (loop_cnt_q != W'(1));
                     state_d    = ST_OPND;
                  end
                  OP_CALL: begin
                     take_d  = 1'b1;
                     state_d = ST_OPND;
                  end
                  OP_RET: begin
                     // Return issues in the opcode cycle itself.
                     branch_en_c = 1'b1;
                     branch_pc_c = link_q;
                  end
                  default: begin
                     // NOP: PC increments.
                  end
               endcase
            end
         end

         ST_OPND: begin
            branch_en_c = take_q;
            branch_pc_c = take_q ? instr : '0;
            state_d     = ST_FETCH;
            if (op_q == OP_LOOP) begin
               loop_cnt_d = instr;
            end
            if (op_q == OP_CALL) begin
               // Return address is the byte after the operand.
               link_d = pc + W'(1);
            end
         end

         ST_HALT: begin
            stop_en_c = 1'b1;
            halted_c  = 1'b1;
         end

         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // State and architectural registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FETCH;
         op_q       <= '0;
         take_q     <= 1'b0;
         loop_cnt_q <= '0;
         link_q     <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         take_q     <= take_d;
         loop_cnt_q <= loop_cnt_d;
         link_q     <= link_d;
      end
   end

   // Reset masks every control output so an aborted OPND/HALT issues nothing.
   always_comb begin
      branch_en = rst ? 1'b0 : branch_en_c;
      branch_pc = rst ? '0   : branch_pc_c;
      stop_en   = rst ? 1'b0 : stop_en_c;
      halted    = rst ? 1'b0 : halted_c;
      loop_cnt  = loop_cnt_q;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: closes the fetch loop with a PC block and program memory,
// and compares every cycle against an instruction-level program model.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pc;
   logic [7:0] instr;
   logic       zero_flag;
   logic       branch_en;
   logic [7:0] branch_pc;
   logic       stop_en;
   logic       halted;
   logic [7:0] loop_cnt;

   logic [7:0] mem [256];
   logic [7:0] start_pc;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected per-cycle trace from the model, observed trace from the DUT.
   logic [7:0] e_pc [256];
   logic [7:0] e_bp [256];
   logic [7:0] e_lc [256];
   logic       e_be [256];
   logic       e_st [256];
   logic       zf   [256];
   logic [7:0] o_pc [256];
   logic [7:0] o_bp [256];
   logic [7:0] o_lc [256];
   logic       o_be [256];
   logic       o_st [256];

   pc_sequencer #(.HALT_OP(8'hFF)) dut (
      .clk       (clk),
      .rst       (rst),
      .pc        (pc),
      .instr     (instr),
      .zero_flag (zero_flag),
      .branch_en (branch_en),
      .branch_pc (branch_pc),
      .stop_en   (stop_en),
      .halted    (halted),
      .loop_cnt  (loop_cnt)
   );

   always #5 clk = ~clk;

   // PC block: reset to start address, hold on stop, load on branch, else increment.
   always @(posedge clk) begin
      if (rst)            pc <= start_pc;
      else if (stop_en)   pc <= pc;
      else if (branch_en) pc <= branch_pc;
      else                pc <= pc + 8'd1;
   end

   always_comb instr = mem[pc];

   task automatic clear_mem();
      for (int a = 0; a < 256; a++) mem[a] = 8'h00;
   endtask

   task automatic put(input int c, input logic [7:0] p, input logic be,
                      input logic [7:0] bp, input logic st, input logic [7:0] lc);
      e_pc[c] = p; e_be[c] = be; e_bp[c] = bp; e_st[c] = st; e_lc[c] = lc;
   endtask

   // Instruction-level model: walks the program one instruction at a time and
   // emits the cycles each instruction occupies.
   task automatic gen_model(input logic [7:0] start, input int n);
      logic [7:0] p, lc, lk, op, opnd, a1;
      logic       tk;
      int         c;
      bit         hlt;
      p = start; lc = 8'h00; lk = 8'h00; c = 0; hlt = 1'b0;
      while (c < n) begin
         if (hlt) begin
            put(c, p, 1'b0, 8'h00, 1'b1, lc);
            c++;
         end else begin
            op = mem[p];
            if (op == 8'hFF) begin
               put(c, p, 1'b0, 8'h00, 1'b0, lc);
               p = p + 8'd1; hlt = 1'b1; c++;
            end else if (op inside {[8'hF0:8'hF4]}) begin
               put(c, p, 1'b0, 8'h00, 1'b0, lc);
               tk = 1'b0;
               if (op == 8'hF0) tk = 1'b1;
               if (op == 8'hF1) tk = zf[c];
               if (op == 8'hF3) begin
                  lc = lc - 8'd1;
                  tk = (lc != 8'h00);
               end
               if (op == 8'hF4) tk = 1'b1;
               c++;
               a1   = p + 8'd1;
               opnd = mem[a1];
               if (c < n) put(c, a1, tk, tk ? opnd : 8'h00, 1'b0, lc);
               c++;
               if (op == 8'hF2) lc = opnd;
               if (op == 8'hF4) lk = p + 8'd2;
               p = tk ? opnd : p + 8'd2;
            end else if (op == 8'hF5) begin
               put(c, p, 1'b1, lk, 1'b0, lc);
               p = lk; c++;
            end else begin
               put(c, p, 1'b0, 8'h00, 1'b0, lc);
               p = p + 8'd1; c++;
            end
         end
      end
   endtask

   // Two reset cycles; outputs must be forced low throughout.
   task automatic do_reset(input logic [7:0] start, input string name);
      rst = 1'b1;
      start_pc = start;
      zero_flag = 1'($urandom_range(0, 1));
      #1;
      n_tests++;
      if (branch_en !== 1'b0 || branch_pc !== 8'h00 || stop_en !== 1'b0 || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL %s reset_a: be=%b bp=%h st=%b h=%b, required all 0",
                  name, branch_en, branch_pc, stop_en, halted);
      end
      @(negedge clk);
      zero_flag = 1'($urandom_range(0, 1));
      #1;
      n_tests++;
      if (branch_en !== 1'b0 || branch_pc !== 8'h00 || stop_en !== 1'b0 ||
          halted !== 1'b0 || loop_cnt !== 8'h00) begin
         n_fail++;
         $display("FAIL %s reset_b: be=%b bp=%h st=%b h=%b lc=%h, required all 0",
                  name, branch_en, branch_pc, stop_en, halted, loop_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   // zf_mode: 0 = zero_flag low, 1 = high, 2 = random each cycle.
   task automatic run(input logic [7:0] start, input int n, input int rst_at,
                      input int zf_mode, input string name);
      for (int i = 0; i < n; i++)
         zf[i] = (zf_mode == 2) ? 1'($urandom_range(0, 1)) : (zf_mode == 1);
      gen_model(start, n);
      do_reset(start, name);
      for (int i = 0; i < n; i++) begin
         zero_flag = zf[i];
         if (i == rst_at) begin
            rst = 1'b1;
            #1;
            n_tests++;
            if (branch_en !== 1'b0 || branch_pc !== 8'h00 || stop_en !== 1'b0 || halted !== 1'b0) begin
               n_fail++;
               $display("FAIL %s midop_rst cyc %0d: be=%b bp=%h st=%b h=%b, required all 0",
                        name, i, branch_en, branch_pc, stop_en, halted);
            end
            @(negedge clk);
            break;
         end
         #1;
         o_pc[i] = pc; o_be[i] = branch_en; o_bp[i] = branch_pc;
         o_lc[i] = loop_cnt; o_st[i] = stop_en;
         n_tests++;
         if (pc !== e_pc[i] || branch_en !== e_be[i] || branch_pc !== e_bp[i] ||
             stop_en !== e_st[i] || halted !== e_st[i] || loop_cnt !== e_lc[i] ||
             (branch_en === 1'b1 && stop_en === 1'b1)) begin
            n_fail++;
            $display("FAIL %s cyc %0d: pc=%h be=%b bp=%h st=%b h=%b lc=%h, required pc=%h be=%b bp=%h st=%b h=%b lc=%h",
                     name, i, pc, branch_en, branch_pc, stop_en, halted, loop_cnt,
                     e_pc[i], e_be[i], e_bp[i], e_st[i], e_st[i], e_lc[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      clear_mem();
      mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'h02;
      run(8'h00, 4, -1, 2, "reset_nop");
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (o_pc[i] !== 8'(i) || o_be[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_nop_pc%0d: pc=%h be=%b, required pc=%h be=0", i, o_pc[i], o_be[i], 8'(i));
         end
      end
   endtask

   task automatic test_jmp();
      clear_mem();
      mem[8'h10] = 8'hF0; mem[8'h11] = 8'h40;
      run(8'h10, 5, -1, 2, "jmp");
      n_tests++;
      if (o_be[1] !== 1'b1 || o_bp[1] !== 8'h40 || o_pc[2] !== 8'h40) begin
         n_fail++;
         $display("FAIL jmp_target: be=%b bp=%h next_pc=%h, required be=1 bp=40 next_pc=40",
                  o_be[1], o_bp[1], o_pc[2]);
      end
   endtask

   task automatic test_jz();
      clear_mem();
      mem[8'h30] = 8'hF1; mem[8'h31] = 8'h20;
      run(8'h30, 4, -1, 0, "jz_nz");
      n_tests++;
      if (o_be[1] !== 1'b0 || o_pc[2] !== 8'h32) begin
         n_fail++;
         $display("FAIL jz_not_taken: be=%b pc=%h, required be=0 pc=32", o_be[1], o_pc[2]);
      end
      run(8'h30, 4, -1, 1, "jz_z");
      n_tests++;
      if (o_be[1] !== 1'b1 || o_pc[2] !== 8'h20) begin
         n_fail++;
         $display("FAIL jz_taken: be=%b pc=%h, required be=1 pc=20", o_be[1], o_pc[2]);
      end
   endtask

   task automatic test_loop();
      int nbr;
      clear_mem();
      mem[0] = 8'hF2; mem[1] = 8'h03; mem[2] = 8'hF3; mem[3] = 8'h02;
      run(8'h00, 10, -1, 2, "loop");
      nbr = 0;
      for (int i = 0; i < 10; i++) if (o_be[i] === 1'b1) nbr++;
      n_tests++;
      if (nbr != 2 || o_pc[8] !== 8'h04) begin
         n_fail++;
         $display("FAIL loop_count: branches=%0d pc=%h, required branches=2 pc=04", nbr, o_pc[8]);
      end
      n_tests++;
      if (o_lc[2] !== 8'd3 || o_lc[3] !== 8'd2 || o_lc[5] !== 8'd1 || o_lc[7] !== 8'd0) begin
         n_fail++;
         $display("FAIL loop_cnt_seq: %0d,%0d,%0d,%0d, required 3,2,1,0",
                  o_lc[2], o_lc[3], o_lc[5], o_lc[7]);
      end
      clear_mem();
      mem[8'h40] = 8'hF3; mem[8'h41] = 8'h55;
      run(8'h40, 4, -1, 2, "djnz_zero");
      n_tests++;
      if (o_lc[1] !== 8'hFF || o_be[1] !== 1'b1 || o_pc[2] !== 8'h55) begin
         n_fail++;
         $display("FAIL djnz_wrap: lc=%h be=%b pc=%h, required lc=ff be=1 pc=55",
                  o_lc[1], o_be[1], o_pc[2]);
      end
   endtask

   task automatic test_call_ret();
      clear_mem();
      mem[8'h05] = 8'hF4; mem[8'h06] = 8'h80; mem[8'h80] = 8'hF5;
      run(8'h05, 6, -1, 2, "call_ret");
      n_tests++;
      if (o_be[2] !== 1'b1 || o_bp[2] !== 8'h07 || o_pc[3] !== 8'h07) begin
         n_fail++;
         $display("FAIL ret_link: be=%b bp=%h pc=%h, required be=1 bp=07 pc=07",
                  o_be[2], o_bp[2], o_pc[3]);
      end
      clear_mem();
      mem[8'hFE] = 8'hF4; mem[8'hFF] = 8'h30; mem[8'h30] = 8'hF5;
      run(8'hFE, 5, -1, 2, "call_wrap");
      n_tests++;
      if (o_be[2] !== 1'b1 || o_bp[2] !== 8'h00) begin
         n_fail++;
         $display("FAIL call_link_wrap: be=%b bp=%h, required be=1 bp=00", o_be[2], o_bp[2]);
      end
      clear_mem();
      mem[8'hFF] = 8'hF0; mem[8'h00] = 8'h12;
      run(8'hFF, 4, -1, 2, "opnd_wrap");
      n_tests++;
      if (o_pc[1] !== 8'h00 || o_pc[2] !== 8'h12) begin
         n_fail++;
         $display("FAIL opnd_wrap: opnd_pc=%h next_pc=%h, required 00 and 12", o_pc[1], o_pc[2]);
      end
   endtask

   task automatic test_halt();
      clear_mem();
      mem[8'h09] = 8'hFF;
      run(8'h09, 5, -1, 2, "halt");
      n_tests++;
      if (o_st[0] !== 1'b0 || o_st[1] !== 1'b1 || o_pc[4] !== 8'h0A) begin
         n_fail++;
         $display("FAIL halt_hold: st0=%b st1=%b pc=%h, required st0=0 st1=1 pc=0a",
                  o_st[0], o_st[1], o_pc[4]);
      end
   endtask

   task automatic test_reset_midop();
      clear_mem();
      mem[8'h20] = 8'hF2; mem[8'h21] = 8'h07;
      mem[8'h22] = 8'hF4; mem[8'h23] = 8'h60;
      run(8'h20, 6, 3, 2, "rst_opnd");
      mem[8'h50] = 8'hF5; mem[8'h00] = 8'hFF;
      run(8'h50, 6, 4, 2, "rst_ret_halt");
      n_tests++;
      if (o_be[0] !== 1'b1 || o_bp[0] !== 8'h00 || o_lc[0] !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_state: be=%b link=%h lc=%h, required be=1 link=00 lc=00",
                  o_be[0], o_bp[0], o_lc[0]);
      end
      run(8'h70, 4, -1, 2, "after_halt");
   endtask

   task automatic test_random();
      int k;
      for (int r = 0; r < 20; r++) begin
         for (int a = 0; a < 256; a++) begin
            k = int'($urandom_range(0, 15));
            if (k < 6)       mem[a] = 8'hF0 + 8'(k);
            else if (k == 6) mem[a] = 8'hFF;
            else if (k == 7) mem[a] = 8'($urandom_range(8'hF6, 8'hFE));
            else             mem[a] = 8'($urandom_range(0, 255));
         end
         run(8'($urandom_range(0, 255)), 150, -1, 2, "random");
      end
   endtask

   initial begin
      rst = 1'b1;
      zero_flag = 1'b0;
      start_pc = 8'h00;
      clear_mem();
      @(negedge clk);
      test_reset();
      test_jmp();
      test_jz();
      test_loop();
      test_call_ret();
      test_halt();
      test_reset_midop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
